// File: rtl/multi_controller_reader_pkg.sv
// Shared constants, button-vector type and reader FSM states for the mapache64 pad reader.
package mapache64;

  localparam int unsigned ControllerNumButtons = 8;
  localparam int unsigned ControllerClkDiv     = 6;

  typedef logic [ControllerNumButtons-1:0] controller_buttons_t;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StShiftHi,
    StShiftLo,
    StDone
  } reader_state_e;

endpackage

// File: rtl/multi_controller_reader_if.sv
// Serial bus shared between the reader (master) and its NES/SNES-style pads (slave).
interface multi_controller_reader_if #(
  parameter int unsigned NUM_CONTROLLERS = 2
);
  logic                       controller_latch;
  logic                       controller_clk_out;
  logic [NUM_CONTROLLERS-1:0] controller_data_in_B;

  modport master (
    output controller_latch,
    output controller_clk_out,
    input  controller_data_in_B
  );

  modport slave (
    input  controller_latch,
    input  controller_clk_out,
    output controller_data_in_B
  );
endinterface

// File: rtl/multi_controller_reader_channel.sv
// One pad's shadow register; the parent decides when to sample and which bit lands where.
module controller_channel #(
  parameter int unsigned NUM_BUTTONS = 8,
  localparam int unsigned IdxW = $clog2(NUM_BUTTONS)
) (
  input  logic                   clk_1,
  input  logic                   rst_B,
  input  logic                   i_sample,
  input  logic [IdxW-1:0]        i_index,
  input  logic                   i_data_in_B,
  output logic [NUM_BUTTONS-1:0] o_shadow
);
  logic [NUM_BUTTONS-1:0] r_shadow;

  // Data line is active-low; store 1 = pressed.
  always_ff @(posedge clk_1 or negedge rst_B) begin
    if (!rst_B) begin
      r_shadow <= '0;
    end else if (i_sample) begin
      r_shadow[i_index] <= ~i_data_in_B;
    end
  end

  assign o_shadow = r_shadow;
endmodule

// File: rtl/multi_controller_reader.sv
// Polls up to four serial pads in lock-step and publishes their button state atomically
// at the end of each poll, along with sticky newly-pressed flags.
module multi_controller_reader
  import mapache64::*;
#(
  parameter int unsigned NUM_CONTROLLERS = 2,
  parameter int unsigned NUM_BUTTONS     = ControllerNumButtons,
  parameter int unsigned CLK_DIV         = ControllerClkDiv
) (
  input  logic                                         clk_1,
  input  logic                                         rst_B,
  input  logic                                         poll_start,
  input  logic                                         clear_pressed,
  multi_controller_reader_if.master                    ctrl_bus,
  output logic [NUM_CONTROLLERS-1:0][NUM_BUTTONS-1:0]  buttons_out,
  output logic [NUM_CONTROLLERS-1:0][NUM_BUTTONS-1:0]  pressed_out,
  output logic                                         busy,
  output logic                                         poll_done
);
  localparam int unsigned CntW = $clog2(CLK_DIV + 1);
  localparam int unsigned IdxW = $clog2(NUM_BUTTONS);
  localparam logic [CntW-1:0] CntReload = CntW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_BUTTONS - 1);

  reader_state_e   r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic            r_half, w_half_next;
  logic [IdxW-1:0] r_idx, w_idx_next;
  logic            w_sample, w_publish, w_cnt_zero;

  logic [NUM_CONTROLLERS-1:0][NUM_BUTTONS-1:0] w_shadow;
  logic [NUM_CONTROLLERS-1:0][NUM_BUTTONS-1:0] r_buttons, r_pressed;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk_1 or negedge rst_B) begin
    if (!rst_B) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_half  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_half  <= w_half_next;
      r_idx   <= w_idx_next;
    end
  end

  // LATCH spans two half-periods; r_half selects which one so the counter stays narrow.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_half_next  = r_half;
    w_idx_next   = r_idx;
    w_sample     = 1'b0;
    w_publish    = 1'b0;
    case (r_state)
      StIdle: begin
        if (poll_start) begin
          w_state_next = StLatch;
          w_cnt_next   = CntReload;
          w_half_next  = 1'b0;
          w_idx_next   = '0;
        end
      end
      StLatch: begin
        if (!w_cnt_zero) begin
          w_cnt_next = r_cnt - CntW'(1);
        end else if (!r_half) begin
          w_half_next = 1'b1;
          w_cnt_next  = CntReload;
        end else begin
          w_sample     = 1'b1;
          w_state_next = StShiftHi;
          w_cnt_next   = CntReload;
          w_idx_next   = r_idx + IdxW'(1);
        end
      end
      StShiftHi: begin
        if (!w_cnt_zero) begin
          w_cnt_next = r_cnt - CntW'(1);
        end else begin
          w_state_next = StShiftLo;
          w_cnt_next   = CntReload;
        end
      end
      StShiftLo: begin
        if (!w_cnt_zero) begin
          w_cnt_next = r_cnt - CntW'(1);
        end else begin
          w_sample   = 1'b1;
          w_cnt_next = CntReload;
          if (r_idx == IdxLast) begin
            w_state_next = StDone;
          end else begin
            w_state_next = StShiftHi;
            w_idx_next   = r_idx + IdxW'(1);
          end
        end
      end
      StDone: begin
        w_publish    = 1'b1;
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
      default: w_state_next = StIdle;
    endcase
  end

  for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_channel
    controller_channel #(
      .NUM_BUTTONS(NUM_BUTTONS)
    ) u_channel (
      .clk_1      (clk_1),
      .rst_B      (rst_B),
      .i_sample   (w_sample),
      .i_index    (r_idx),
      .i_data_in_B(ctrl_bus.controller_data_in_B[g]),
      .o_shadow   (w_shadow[g])
    );
  end

  // A clear coincident with publish drops old flags but keeps this poll's new edges.
  always_ff @(posedge clk_1 or negedge rst_B) begin
    if (!rst_B) begin
      r_buttons <= '0;
      r_pressed <= '0;
    end else if (w_publish) begin
      r_buttons <= w_shadow;
      r_pressed <= (clear_pressed ? '0 : r_pressed) | (w_shadow & ~r_buttons);
    end else if (clear_pressed) begin
      r_pressed <= '0;
    end
  end

  assign ctrl_bus.controller_latch   = (r_state == StLatch);
  assign ctrl_bus.controller_clk_out = (r_state == StShiftHi);
  assign busy                        = (r_state != StIdle);
  assign poll_done                   = (r_state == StDone);
  assign buttons_out                 = r_buttons;
  assign pressed_out                 = r_pressed;
endmodule

// File: tb/tb_multi_controller_reader.sv
// Bench for multi_controller_reader: three configurations driven by pad models, with a
// cycle-level behavioural model checked on every cycle of the main instance.
module tb_multi_controller_reader;
  import mapache64::*;

  localparam int A_CD = 1;
  localparam int A_NB = 8;
  localparam int AP   = 2 * A_CD * A_NB + 1;
  localparam int C_NB = 16;

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic nes_bit(input logic [15:0] pat, input int pos, input int nb);
    logic [3:0] p;
    p = pos[3:0];
    return (pos < nb) ? ~pat[p] : 1'b0;
  endfunction

  // ---------------- instance A: 2 pads, 8 buttons, CLK_DIV=1 ----------------
  logic rst_a, a_start, a_clear, a_busy, a_done;
  controller_buttons_t [1:0] a_pat;
  logic [1:0][7:0] a_buttons, a_pressed;
  multi_controller_reader_if #(.NUM_CONTROLLERS(2)) if_a ();

  multi_controller_reader #(.NUM_CONTROLLERS(2), .NUM_BUTTONS(8), .CLK_DIV(A_CD)) u_a (
    .clk_1(clk), .rst_B(rst_a), .poll_start(a_start), .clear_pressed(a_clear),
    .ctrl_bus(if_a), .buttons_out(a_buttons), .pressed_out(a_pressed),
    .busy(a_busy), .poll_done(a_done)
  );

  // ---------------- instance B: 2 pads, 8 buttons, CLK_DIV=6 ----------------
  logic rst_b, b_start, b_busy, b_done;
  logic [1:0][7:0] b_pat, b_buttons, b_pressed;
  multi_controller_reader_if #(.NUM_CONTROLLERS(2)) if_b ();

  multi_controller_reader #(.NUM_CONTROLLERS(2), .NUM_BUTTONS(8), .CLK_DIV(6)) u_b (
    .clk_1(clk), .rst_B(rst_b), .poll_start(b_start), .clear_pressed(1'b0),
    .ctrl_bus(if_b), .buttons_out(b_buttons), .pressed_out(b_pressed),
    .busy(b_busy), .poll_done(b_done)
  );

  // ---------------- instance C: 4 pads, 16 buttons, CLK_DIV=2 ----------------
  logic rst_c, c_start, c_busy, c_done, c_disc;
  logic [3:0][15:0] c_pat, c_buttons, c_pressed;
  multi_controller_reader_if #(.NUM_CONTROLLERS(4)) if_c ();

  multi_controller_reader #(.NUM_CONTROLLERS(4), .NUM_BUTTONS(C_NB), .CLK_DIV(2)) u_c (
    .clk_1(clk), .rst_B(rst_c), .poll_start(c_start), .clear_pressed(1'b0),
    .ctrl_bus(if_c), .buttons_out(c_buttons), .pressed_out(c_pressed),
    .busy(c_busy), .poll_done(c_done)
  );

  // ---------------- pad models: latch loads, each clk rise advances ----------------
  int a_pos = 0, b_pos = 0, c_pos = 0;
  always @(posedge if_a.controller_latch or posedge if_a.controller_clk_out)
    a_pos <= if_a.controller_latch ? 0 : a_pos + 1;
  always @(posedge if_b.controller_latch or posedge if_b.controller_clk_out)
    b_pos <= if_b.controller_latch ? 0 : b_pos + 1;
  always @(posedge if_c.controller_latch or posedge if_c.controller_clk_out)
    c_pos <= if_c.controller_latch ? 0 : c_pos + 1;

  assign if_a.controller_data_in_B = {nes_bit({8'h00, a_pat[1]}, a_pos, 8),
                                      nes_bit({8'h00, a_pat[0]}, a_pos, 8)};
  assign if_b.controller_data_in_B = {nes_bit({8'h00, b_pat[1]}, b_pos, 8),
                                      nes_bit({8'h00, b_pat[0]}, b_pos, 8)};
  assign if_c.controller_data_in_B = {c_disc ? 1'b1 : nes_bit(c_pat[3], c_pos, C_NB),
                                      nes_bit(c_pat[2], c_pos, C_NB),
                                      nes_bit(c_pat[1], c_pos, C_NB),
                                      nes_bit(c_pat[0], c_pos, C_NB)};

  // ---------------- behavioural model of instance A ----------------
  // m_t = position within the current poll (1 .. AP), 0 when idle.
  int m_t;
  logic [1:0][7:0] m_buttons, m_pressed, m_shadow;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      m_t       <= 0;
      m_buttons <= '0;
      m_pressed <= '0;
      m_shadow  <= '0;
    end else if (m_t == AP) begin
      m_pressed <= (a_clear ? '0 : m_pressed) | (m_shadow & ~m_buttons);
      m_buttons <= m_shadow;
      m_t       <= 0;
    end else begin
      if (a_clear) m_pressed <= '0;
      if (m_t != 0) begin
        m_t <= m_t + 1;
      end else if (a_start) begin
        m_t      <= 1;
        m_shadow <= a_pat;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("a_busy", a_busy, m_t != 0);
    check("a_latch", if_a.controller_latch, (m_t >= 1) && (m_t <= 2 * A_CD));
    check("a_clk_out", if_a.controller_clk_out,
          (m_t > 2 * A_CD) && (m_t < AP) && (((m_t - 2 * A_CD - 1) / A_CD) % 2 == 0));
    check("a_poll_done", a_done, m_t == AP);
    check("a_buttons", a_buttons, m_buttons);
    check("a_pressed", a_pressed, m_pressed);
  end

  int a_done_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (a_done === 1'b1) a_done_cnt <= a_done_cnt + 1;
  end

  // Called at a falling edge while A is idle; returns one cycle after DONE.
  task automatic a_poll(input bit clr_at_done);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (AP - 1) @(negedge clk);
    a_clear = clr_at_done;
    @(negedge clk);
    a_clear = 1'b0;
  endtask

  bit s_l[0:110], s_c[0:110], s_b[0:110], s_d[0:110];

  initial begin
    int d0, nl, nb, nd, np, first_rise, last_busy, rise_k, fall_k;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    a_start = 1'b0; a_clear = 1'b0; b_start = 1'b0; c_start = 1'b0; c_disc = 1'b0;
    a_pat = '0; b_pat = '0; c_pat = '0;
    repeat (3) @(negedge clk);

    check("rst_a_buttons", a_buttons, 16'h0000);
    check("rst_a_pressed", a_pressed, 16'h0000);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_done", a_done, 1'b0);
    check("rst_a_latch", if_a.controller_latch, 1'b0);
    check("rst_a_clk", if_a.controller_clk_out, 1'b0);
    check("rst_b_pressed", b_pressed, 16'h0000);
    check("rst_c_buttons", c_buttons, 64'h0);
    check("rst_c_pressed", c_pressed, 64'h0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);

    // Two NES pads, one poll
    a_pat = {8'b11111110, 8'b01111111};
    d0 = a_done_cnt;
    a_poll(1'b0);
    check("nes_buttons", a_buttons, 16'hFE7F);
    check("nes_model_buttons", m_buttons, 16'hFE7F);
    check("nes_done_count", a_done_cnt - d0, 1);

    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    check("clear_pressed", a_pressed, 16'h0000);

    // Newly-pressed edge flags
    a_pat = '0;       a_poll(1'b0);
    a_pat = 16'h0005; a_poll(1'b0);
    check("press_first", a_pressed[0], 8'h05);
    a_pat = 16'h0004; a_poll(1'b0);
    check("press_retained", a_pressed[0], 8'h05);
    a_pat = 16'h000C; a_poll(1'b1);
    check("press_clear_at_done", a_pressed[0], 8'h08);
    check("press_model_clear_at_done", m_pressed, 16'h0008);

    // poll_start repeated mid-poll is dropped
    d0 = a_done_cnt;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    repeat (2) @(negedge clk);
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    repeat (6) @(negedge clk);
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    repeat (20) @(negedge clk);
    check("ignored_done_count", a_done_cnt - d0, 1);

    // Reset during SHIFT aborts without publishing
    a_pat = 16'h3355;
    d0 = a_done_cnt;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    repeat (5) @(negedge clk);
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_buttons", a_buttons, 16'h0000);
    check("abort_busy", a_busy, 1'b0);
    check("abort_latch", if_a.controller_latch, 1'b0);
    check("abort_clk", if_a.controller_clk_out, 1'b0);
    rst_a = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_stays_idle", a_busy, 1'b0);
    check("abort_no_done", a_done_cnt - d0, 0);
    a_poll(1'b0);
    check("after_abort_buttons", a_buttons, 16'h3355);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if (m_t == 0 && $urandom_range(0, 3) == 0) begin
        a_pat = 16'($urandom);
        if ($urandom_range(0, 7) == 0) a_pat[1] = '0;
      end
      a_start = ($urandom_range(0, 5) == 0);
      a_clear = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    a_start = 1'b0;
    a_clear = 1'b0;

    // Latch / serial clock timing with CLK_DIV=6
    b_pat = {8'h3C, 8'hA5};
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    s_c[0] = 1'b0;
    for (int k = 1; k <= 110; k++) begin
      s_l[k] = if_b.controller_latch;
      s_c[k] = if_b.controller_clk_out;
      s_b[k] = b_busy;
      s_d[k] = b_done;
      @(posedge clk); #1;
    end
    nl = 0; nb = 0; nd = 0; np = 0; first_rise = 0; last_busy = 0; rise_k = 0; fall_k = 0;
    for (int k = 1; k <= 110; k++) begin
      nl += int'(s_l[k]);
      nb += int'(s_b[k]);
      nd += int'(s_d[k]);
      if (s_b[k]) last_busy = k;
      if (s_c[k] && !s_c[k-1]) begin
        np++;
        if (np == 1) first_rise = k;
        else check("b_low_len", k - fall_k, 6);
        rise_k = k;
      end
      if (!s_c[k] && s_c[k-1]) begin
        check("b_high_len", k - rise_k, 6);
        fall_k = k;
      end
    end
    check("b_latch_first", s_l[1], 1'b1);
    check("b_latch_cycles", nl, 12);
    check("b_first_clk_rise", first_rise, 13);
    check("b_clk_pulses", np, 7);
    check("b_busy_cycles", nb, 97);
    check("b_busy_last", last_busy, 97);
    check("b_done_pulses", nd, 1);
    check("b_buttons", b_buttons, 16'h3CA5);

    // SNES width, four pads, then pad 3 disconnected
    @(negedge clk);
    c_pat = {16'h1008, 16'h2004, 16'h4002, 16'h8001};
    c_start = 1'b1; @(negedge clk); c_start = 1'b0;
    repeat (70) @(negedge clk);
    check("snes_ch0", c_buttons[0], 16'h8001);
    check("snes_ch1", c_buttons[1], 16'h4002);
    check("snes_ch2", c_buttons[2], 16'h2004);
    check("snes_ch3", c_buttons[3], 16'h1008);
    c_disc = 1'b1;
    c_start = 1'b1; @(negedge clk); c_start = 1'b0;
    repeat (70) @(negedge clk);
    check("snes_disc_ch3", c_buttons[3], 16'h0000);
    check("snes_disc_ch0", c_buttons[0], 16'h8001);
    check("snes_disc_busy", c_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
